// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state codes, Rcon table and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ROUND = 4'd1,
        ST_DONE  = 4'd2
    } aes_state_e;

    localparam logic [4:0] LAST_ROUND = 5'd10;

    // Round constant for the key expansion step that produces K_r.
    function automatic logic [7:0] rcon(input logic [4:0] r);
        logic [7:0] v;
        case (r)
            5'd1:    v = 8'h01;
            5'd2:    v = 8'h02;
            5'd3:    v = 8'h04;
            5'd4:    v = 8'h08;
            5'd5:    v = 8'h10;
            5'd6:    v = 8'h20;
            5'd7:    v = 8'h40;
            5'd8:    v = 8'h80;
            5'd9:    v = 8'h1b;
            5'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Byte k of the state lives at bits [127-8k -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    // MixColumns on one column; a0 is the most significant byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] inv;

    // Inverse then affine map b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes.sv
// Iterative AES-128 encryption core: one round per clock, key schedule expanded on the fly.
module aes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         data_vaild,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         ready,
    output logic [3:0]   state,
    output logic [127:0] internal_data,
    output logic [127:0] subbyted,
    output logic [127:0] shifted,
    output logic [127:0] mixcolumned,
    output logic [127:0] addroundkeyed,
    output logic [4:0]   nround
);

    aes_state_e   state_q, state_d;
    logic [4:0]   nround_q, nround_d;
    logic [127:0] data_q, data_d;
    // Holds K_(r-1) while round r runs; K_r is derived from it combinationally.
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic         ready_q, ready_d;

    logic [127:0] mixed_all;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [127:0] round_key;

    // SubBytes: one S-box per state byte.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_subbytes
            aes_sbox u_sbox (
                .in_byte  (data_q[127 - 8*gi -: 8]),
                .out_byte (subbyted[127 - 8*gi -: 8])
            );
        end
    endgenerate

    assign shifted = shift_rows(subbyted);

    // MixColumns on each column; the final round bypasses it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mixcol
            assign mixed_all[127 - 32*gi -: 32] = mix_column(shifted[127 - 32*gi -: 32]);
        end
    endgenerate

    assign mixcolumned = (nround_q == LAST_ROUND) ? shifted : mixed_all;

    // Key schedule: RotWord of the last word, then SubWord through four S-boxes.
    assign rot_word = {key_q[23:0], key_q[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .in_byte  (rot_word[31 - 8*gi -: 8]),
                .out_byte (sub_word[31 - 8*gi -: 8])
            );
        end
    endgenerate

    // Next round key K_r from K_(r-1) using Rcon[nround].
    always_comb begin
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        t  = sub_word ^ {rcon(nround_q), 24'h0};
        w0 = key_q[127:96] ^ t;
        w1 = key_q[95:64]  ^ w0;
        w2 = key_q[63:32]  ^ w1;
        w3 = key_q[31:0]   ^ w2;
        round_key = {w0, w1, w2, w3};
    end

    assign addroundkeyed = mixcolumned ^ round_key;

    // Next-state and datapath update for the IDLE / ROUND / DONE controller.
    always_comb begin
        state_d  = state_q;
        nround_d = nround_q;
        data_d   = data_q;
        key_d    = key_q;
        out_d    = out_q;
        ready_d  = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (data_vaild) begin
                    data_d   = in ^ key;
                    key_d    = key;
                    nround_d = 5'd1;
                    ready_d  = 1'b0;
                    state_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                data_d = addroundkeyed;
                key_d  = round_key;
                if (nround_q == LAST_ROUND) begin
                    out_d   = addroundkeyed;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    nround_d = nround_q + 5'd1;
                end
            end
            ST_DONE: begin
                // Stay here while the producer still holds its request up.
                if (!data_vaild) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            nround_q <= 5'd0;
            data_q   <= '0;
            key_q    <= '0;
            out_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            nround_q <= nround_d;
            data_q   <= data_d;
            key_q    <= key_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
        end
    end

    assign out           = out_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign internal_data = data_q;
    assign nround        = nround_q;

endmodule

// File: tb/tb_aes.sv
// Directed bench for the iterative AES-128 core using FIPS-197 vectors.
module tb_aes;

    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_ARK0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] B_SB1  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] B_SR1  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] B_MC1  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] B_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         data_vaild;
    logic [127:0] din;
    logic [127:0] dkey;
    logic [127:0] out;
    logic         ready;
    logic [3:0]   state;
    logic [127:0] internal_data;
    logic [127:0] subbyted;
    logic [127:0] shifted;
    logic [127:0] mixcolumned;
    logic [127:0] addroundkeyed;
    logic [4:0]   nround;

    int checks;
    int failures;

    aes dut (
        .clk           (clk),
        .rst           (rst),
        .data_vaild    (data_vaild),
        .in            (din),
        .key           (dkey),
        .out           (out),
        .ready         (ready),
        .state         (state),
        .internal_data (internal_data),
        .subbyted      (subbyted),
        .shifted       (shifted),
        .mixcolumned   (mixcolumned),
        .addroundkeyed (addroundkeyed),
        .nround        (nround)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        data_vaild = 1'b0;
        din        = '0;
        dkey       = '0;

        // Reset state
        tick();
        check("rst_state", 128'(state), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_out", out, 128'd0);
        check("rst_nround", 128'(nround), 128'd0);
        check("rst_data", internal_data, 128'd0);
        $display("txn reset done");
        rst = 1'b0;

        // App.B accept
        data_vaild = 1'b1;
        din        = B_PT;
        dkey       = B_KEY;
        tick();
        check("b_accept_data", internal_data, B_ARK0);
        check("b_accept_nround", 128'(nround), 128'd1);
        check("b_accept_state", 128'(state), 128'd1);
        check("b_accept_ready", 128'(ready), 128'd0);
        check("b_r1_subbytes", subbyted, B_SB1);
        check("b_r1_shiftrows", shifted, B_SR1);
        check("b_r1_mixcolumns", mixcolumned, B_MC1);
        check("b_r1_key", addroundkeyed ^ mixcolumned, B_K1);
        $display("txn appB accepted");

        // Inputs change while busy and must be ignored; request stays asserted
        din  = C_PT;
        dkey = C_KEY;
        tick();
        check("b_round1_data", internal_data, B_R1);
        check("b_round1_nround", 128'(nround), 128'd2);
        repeat (8) tick();
        check("b_r10_nround", 128'(nround), 128'd10);
        check("b_r10_state", 128'(state), 128'd1);
        check("b_r10_ready", 128'(ready), 128'd0);
        check("b_r10_key", addroundkeyed ^ mixcolumned, B_K10);
        check("b_r10_nomix", mixcolumned, shifted);
        tick();
        check("b_done_ready", 128'(ready), 128'd1);
        check("b_done_out", out, B_CT);
        check("b_done_state", 128'(state), 128'd2);
        $display("txn appB out=%h ready=%0d", out, ready);

        // Hold in DONE while data_vaild stays high
        for (int i = 0; i < 22; i++) begin
            tick();
            check("hold_ready", 128'(ready), 128'd1);
            check("hold_out", out, B_CT);
            check("hold_state", 128'(state), 128'd2);
        end
        $display("txn hold 22 cycles");

        // Drop request -> IDLE with result still visible
        data_vaild = 1'b0;
        tick();
        check("idle_state", 128'(state), 128'd0);
        check("idle_ready", 128'(ready), 128'd1);
        check("idle_out", out, B_CT);

        // App.C second block
        data_vaild = 1'b1;
        din        = C_PT;
        dkey       = C_KEY;
        tick();
        check("c_accept_ready", 128'(ready), 128'd0);
        check("c_accept_state", 128'(state), 128'd1);
        data_vaild = 1'b0;
        repeat (9) tick();
        check("c_r10_ready", 128'(ready), 128'd0);
        tick();
        check("c_done_ready", 128'(ready), 128'd1);
        check("c_done_out", out, C_CT);
        $display("txn appC out=%h ready=%0d", out, ready);
        tick();
        check("c_idle_state", 128'(state), 128'd0);

        // Mid-operation reset at round 5
        data_vaild = 1'b1;
        din        = B_PT;
        dkey       = B_KEY;
        tick();
        data_vaild = 1'b0;
        repeat (4) tick();
        check("mid_nround5", 128'(nround), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_state", 128'(state), 128'd0);
        check("mid_ready", 128'(ready), 128'd0);
        check("mid_out", out, 128'd0);
        check("mid_nround", 128'(nround), 128'd0);
        check("mid_data", internal_data, 128'd0);
        $display("txn mid-op reset");
        repeat (12) tick();
        check("mid_stays_idle", 128'(ready), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
